// File: rtl/anotherworld_thread_scheduler.sv
// Per-frame VM thread scheduler: commits setVec/updateChannel requests, then hands runnable threads to the CPU in ID order.
// Define ANOTHERWORLD_SCHED_STATS_EN to add the saturating per-frame dispatch_count output.
module anotherworld_thread_scheduler #(
  parameter int NUM_THREADS = 64,
  parameter int PC_W = 16,
  localparam int TW = $clog2(NUM_THREADS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic            setvec_valid,
  input  logic [TW-1:0]   setvec_id,
  input  logic [PC_W-1:0] setvec_pc,
  input  logic            chan_valid,
  input  logic [TW-1:0]   chan_first,
  input  logic [TW-1:0]   chan_last,
  input  logic [1:0]      chan_type,
  output logic            run_valid,
  output logic [TW-1:0]   run_id,
  output logic [PC_W-1:0] run_pc,
  input  logic            run_ready,
  input  logic            done_valid,
  input  logic [PC_W-1:0] done_pc,
  input  logic            done_kill,
  output logic            busy,
  output logic            frame_done
`ifdef ANOTHERWORLD_SCHED_STATS_EN
  ,
  output logic [7:0]      dispatch_count
`endif
);

  localparam logic [PC_W-1:0] PC_NONE = '1;
  localparam logic [PC_W-1:0] PC_KILL = {{(PC_W-1){1'b1}}, 1'b0};
  localparam logic [TW-1:0]   LAST    = TW'(NUM_THREADS - 1);

  typedef enum logic [2:0] {IDLE, APPLY, SCAN, DISPATCH, WAIT, FINISH} state_t;

  state_t                 state;
  logic [TW-1:0]          idx;
  logic [PC_W-1:0]        pc     [NUM_THREADS];
  logic [PC_W-1:0]        req_pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] paused;
  logic [NUM_THREADS-1:0] req_pause_vld;
  logic [NUM_THREADS-1:0] req_pause;
  logic [NUM_THREADS-1:0] chan_sel;
`ifdef ANOTHERWORLD_SCHED_STATS_EN
  logic [7:0]             frame_cnt;
`endif

  // An inverted range selects nothing because no thread satisfies both bounds.
  always_comb begin
    chan_sel = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      chan_sel[i] = chan_valid && (chan_type != 2'd3) &&
                    (TW'(i) >= chan_first) && (TW'(i) <= chan_last);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      run_valid     <= 1'b0;
      run_id        <= '0;
      run_pc        <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      paused        <= '0;
      req_pause_vld <= '0;
      req_pause     <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc[i]     <= (i == 0) ? '0 : PC_NONE;
        req_pc[i] <= PC_NONE;
      end
`ifdef ANOTHERWORLD_SCHED_STATS_EN
      frame_cnt      <= '0;
      dispatch_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= APPLY;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef ANOTHERWORLD_SCHED_STATS_EN
            frame_cnt <= '0;
`endif
          end
        end
        APPLY: begin
          if (req_pc[idx] == PC_KILL)      pc[idx] <= PC_NONE;
          else if (req_pc[idx] != PC_NONE) pc[idx] <= req_pc[idx];
          if (req_pause_vld[idx]) paused[idx] <= req_pause[idx];
          req_pc[idx]        <= PC_NONE;
          req_pause_vld[idx] <= 1'b0;
          idx <= idx + 1'b1;
          if (idx == LAST) state <= SCAN;
        end
        SCAN: begin
          if (pc[idx] != PC_NONE && !paused[idx]) begin
            state     <= DISPATCH;
            run_valid <= 1'b1;
            run_id    <= idx;
            run_pc    <= pc[idx];
          end else if (idx == LAST) begin
            state      <= FINISH;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DISPATCH: begin
          if (run_ready) begin
            state     <= WAIT;
            run_valid <= 1'b0;
`ifdef ANOTHERWORLD_SCHED_STATS_EN
            if (frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
`endif
          end
        end
        WAIT: begin
          if (done_valid) begin
            pc[idx] <= done_kill ? PC_NONE : done_pc;
            if (idx == LAST) begin
              state      <= FINISH;
              frame_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end
        end
        FINISH: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
`ifdef ANOTHERWORLD_SCHED_STATS_EN
          dispatch_count <= frame_cnt;
`endif
        end
        default: state <= IDLE;
      endcase

      // Capture comes after APPLY's clear so a same-cycle request survives into the next frame;
      // chan kill is written last so it beats a simultaneous setVec.
      if (setvec_valid) req_pc[setvec_id] <= setvec_pc;
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (chan_sel[i]) begin
          if (chan_type == 2'd2) begin
            req_pc[i] <= PC_KILL;
          end else begin
            req_pause_vld[i] <= 1'b1;
            req_pause[i]     <= chan_type[0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_anotherworld_thread_scheduler.sv
// Scoreboard bench: per-frame dispatch list predicted from a thread-table model, checked by an independent monitor.
module tb_anotherworld_thread_scheduler;
  localparam int N  = 64;
  localparam int TW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          setvec_valid;
  logic [TW-1:0] setvec_id;
  logic [15:0]   setvec_pc;
  logic          chan_valid;
  logic [TW-1:0] chan_first;
  logic [TW-1:0] chan_last;
  logic [1:0]    chan_type;
  logic          run_valid;
  logic [TW-1:0] run_id;
  logic [15:0]   run_pc;
  logic          run_ready;
  logic          done_valid;
  logic [15:0]   done_pc;
  logic          done_kill;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  anotherworld_thread_scheduler #(.NUM_THREADS(N), .PC_W(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .setvec_valid(setvec_valid), .setvec_id(setvec_id), .setvec_pc(setvec_pc),
    .chan_valid(chan_valid), .chan_first(chan_first), .chan_last(chan_last), .chan_type(chan_type),
    .run_valid(run_valid), .run_id(run_id), .run_pc(run_pc), .run_ready(run_ready),
    .done_valid(done_valid), .done_pc(done_pc), .done_kill(done_kill),
    .busy(busy), .frame_done(frame_done)
  );

  int total = 0;
  int bad   = 0;
  int m_pc[N], m_paused[N], m_req[N], m_pv[N], m_p[N];
  int exp_id[$];
  int exp_pc[$];
  int hs_count = 0;
  int fd_count = 0;
  int stall_cfg = -1;
  int force_pc = 0;
  int force_kill_id = -1;
  bit hold_done = 0, force_pc_vld = 0, rand_req_en = 0, rand_kill_en = 0;
  bit inj_vld = 0;
  int inj_id, inj_pc;
  bit pv = 0, pr = 0;
  int pid, ppc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pc[i] = (i == 0) ? 0 : 16'hFFFF;
      m_paused[i] = 0; m_req[i] = 16'hFFFF; m_pv[i] = 0; m_p[i] = 0;
    end
  endtask

  // One request cycle on the DUT ports, mirrored into the model's pending requests.
  task automatic do_req(input bit sv, input int id, input int pc,
                        input bit cv, input int cf, input int cl, input int ct);
    setvec_valid = sv; setvec_id = TW'(id); setvec_pc = 16'(pc);
    chan_valid = cv; chan_first = TW'(cf); chan_last = TW'(cl); chan_type = 2'(ct);
    if (sv) m_req[id] = pc;
    if (cv && ct != 3) begin
      for (int i = cf; i <= cl; i++) begin
        if (ct == 2) m_req[i] = 16'hFFFE;
        else begin m_pv[i] = 1; m_p[i] = ct & 1; end
      end
    end
    @(posedge clk); #1;
    setvec_valid = 0; chan_valid = 0;
  endtask

  task automatic rand_req();
    int f, l, t, pc;
    f  = $urandom_range(0, N-1);
    l  = f + $urandom_range(0, 5);
    if (l > N-1) l = N-1;
    if ($urandom_range(0, 7) == 0 && f > 0) l = f - 1;
    t  = $urandom_range(0, 3);
    pc = ($urandom_range(0, 15) == 0) ? 16'hFFFE : $urandom_range(0, 16'hFFFD);
    do_req($urandom_range(0, 3) != 0, $urandom_range(0, N-1), pc, $urandom_range(0, 3) == 0, f, l, t);
  endtask

  task automatic start_frame();
    for (int i = 0; i < N; i++) begin
      if (m_req[i] == 16'hFFFE) m_pc[i] = 16'hFFFF;
      else if (m_req[i] != 16'hFFFF) m_pc[i] = m_req[i];
      if (m_pv[i]) m_paused[i] = m_p[i];
      m_req[i] = 16'hFFFF; m_pv[i] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_pc[i] != 16'hFFFF && !m_paused[i]) begin
        exp_id.push_back(i); exp_pc.push_back(m_pc[i]);
      end
    end
    frame_start = 1;
    @(posedge clk); #1;
    frame_start = 0;
  endtask

  task automatic run_frame(input int exp_cyc);
    int cyc, fd0;
    fd0 = fd_count;
    start_frame();
    cyc = 0;
    while (cyc < 6000) begin
      @(negedge clk); cyc++;
      if (frame_done) break;
    end
    if (!frame_done) begin
      total++; bad++;
      $display("FAIL frame_timeout actual=no frame_done required=frame_done within 6000 cycles");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    if (exp_cyc >= 0) check("frame_cycles", cyc, exp_cyc);
    @(negedge clk);
    check("frame_done_width", frame_done, 0);
    check("idle_busy", busy, 0);
    check("frame_done_count", fd_count - fd0, 1);
  endtask

  // CPU model: accepts dispatches after a stall, optionally raises requests, then yields.
  initial begin : cpu
    int st, id, dpc;
    bit dk;
    run_ready = 0; done_valid = 0; done_pc = '0; done_kill = 0;
    forever begin
      @(posedge clk); #1;
      if (reset && run_valid) begin
        st = (stall_cfg >= 0) ? stall_cfg : $urandom_range(0, 3);
        repeat (st) begin @(posedge clk); #1; end
        id = int'(run_id);
        run_ready = 1;
        @(posedge clk); #1;
        run_ready = 0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        if (inj_vld) begin
          inj_vld = 0;
          do_req(1, inj_id, inj_pc, 0, 0, 0, 3);
        end else if (rand_req_en && $urandom_range(0, 1) == 1) begin
          rand_req();
        end
        while (hold_done && reset) begin @(posedge clk); #1; end
        if (reset) begin
          dpc = force_pc_vld ? force_pc : int'($urandom_range(0, 16'hFFF0));
          dk  = (id == force_kill_id) || (rand_kill_en && $urandom_range(0, 7) == 0);
          done_valid = 1; done_pc = 16'(dpc); done_kill = dk;
          m_pc[id] = dk ? 16'hFFFF : dpc;
          @(posedge clk); #1;
          done_valid = 0; done_kill = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (!reset) begin
      pv = 0; pr = 0;
    end else begin
      if (pv && !pr) check("offer_stable", {run_valid, run_id, run_pc}, {1'b1, 6'(pid), 16'(ppc)});
      if (run_valid && run_ready) begin
        hs_count++;
        if (exp_id.size() == 0) begin
          total++; bad++;
          $display("FAIL dispatch_extra actual=id %0d pc 0x%0h required=no dispatch", run_id, run_pc);
        end else begin
          check("dispatch_id", int'(run_id), exp_id.pop_front());
          check("dispatch_pc", int'(run_pc), exp_pc.pop_front());
        end
      end
      if (frame_done) begin
        fd_count++;
        check("frame_drain", exp_id.size(), 0);
      end
      pv = run_valid; pr = run_ready; pid = int'(run_id); ppc = int'(run_pc);
    end
  end

  initial begin : main
    int hs0, cyc;
    frame_start = 0; setvec_valid = 0; setvec_id = '0; setvec_pc = '0;
    chan_valid = 0; chan_first = '0; chan_last = '0; chan_type = '0;
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_run_valid", run_valid, 0);
    check("rst_run_id", run_id, 0);
    check("rst_run_pc", run_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1;
    @(posedge clk); #1;

    force_pc_vld = 1; force_pc = 16'h0042;
    run_frame(-1);
    force_pc_vld = 0;
    run_frame(-1);

    inj_vld = 1; inj_id = 5; inj_pc = 16'h1234;
    run_frame(-1);
    run_frame(-1);

    do_req(1, 3, 16'h0300, 0, 0, 0, 3);
    do_req(1, 4, 16'h0400, 0, 0, 0, 3);
    do_req(1, 6, 16'h0600, 0, 0, 0, 3);
    run_frame(-1);
    do_req(0, 0, 0, 1, 3, 6, 1);
    run_frame(-1);
    do_req(0, 0, 0, 1, 3, 6, 0);
    run_frame(-1);

    do_req(1, 4, 16'h0777, 1, 4, 4, 2);
    force_kill_id = 3;
    run_frame(-1);
    force_kill_id = -1;
    run_frame(-1);

    do_req(1, 9, 16'h0900, 1, 9, 7, 2);
    do_req(0, 0, 0, 1, 0, N-1, 3);
    run_frame(-1);

    do_req(0, 0, 0, 1, 0, N-1, 2);
    run_frame(2*N+1);
    run_frame(2*N+1);

    do_req(1, 0, 16'h0100, 0, 0, 0, 3);
    stall_cfg = 10; hold_done = 1;
    hs0 = hs_count;
    start_frame();
    cyc = 0;
    while (hs_count == hs0 && cyc < 2000) begin @(negedge clk); cyc++; end
    check("wait_reached", (hs_count != hs0) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    check("wait_busy", busy, 1);
    #2 reset = 0;
    #1;
    check("midrst_run_valid", run_valid, 0);
    check("midrst_run_id", run_id, 0);
    check("midrst_run_pc", run_pc, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    hold_done = 0; stall_cfg = -1;
    exp_id.delete(); exp_pc.delete();
    model_reset();
    repeat (3) @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    run_frame(-1);

    rand_req_en = 1; rand_kill_en = 1;
    repeat (25) begin
      repeat ($urandom_range(0, 4)) rand_req();
      run_frame(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anotherworld_thread_scheduler.md
Name: anotherworld_thread_scheduler

Overview:
- Per-frame thread scheduler for the bytecode CPU. Holds PC and pause state for all VM threads.
- At each frame_start it commits the requests raised by setVec (0x08) and updateChannel (0x0C). It then hands each active, unpaused thread to the CPU in ascending ID order, one at a time.
- Sits between the frame timer and the CPU fetch/execute core. The CPU returns control on pauseThread (0x06) or killThread (0x11).

Parameters:
- NUM_THREADS, 64, number of VM threads (power of 2); ID width TW = log2(NUM_THREADS).
- PC_W, 16, bytecode PC width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; begin a frame
- setvec_valid  in  1  setVec request strobe
- setvec_id  in  TW  target thread
- setvec_pc  in  PC_W  requested PC; 0xFFFE = kill request
- chan_valid  in  1  updateChannel request strobe
- chan_first  in  TW  first thread of range
- chan_last  in  TW  last thread of range (inclusive)
- chan_type  in  2  0 = resume, 1 = pause, 2 = kill, 3 = ignored
- run_valid  out  1  dispatch offer to CPU
- run_id  out  TW  thread being dispatched
- run_pc  out  PC_W  start PC of the dispatched thread
- run_ready  in  1  CPU accepts the dispatch
- done_valid  in  1  CPU yields the current thread
- done_pc  in  PC_W  resume PC on yield
- done_kill  in  1  thread executed killThread
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Storage per thread:
  - pc: 0xFFFF = inactive.
  - paused.
  - req_pc: 0xFFFF = no request.
  - req_pause_vld, req_pause.
- Reset values:
  - pc[0] = 0; pc[others] = 0xFFFF; paused = 0.
  - req_pc = 0xFFFF; req_pause_vld = 0.
  - All outputs 0; state IDLE.
  - Reset mid-frame aborts immediately to these values.
- Request capture is accepted in any state, one request per cycle per port, and only writes request arrays:
  - setvec writes req_pc[id].
  - chan applies to every thread in first..last:
    - types 0/1 set req_pause_vld = 1 and req_pause = type[0].
    - type 2 sets req_pc = 0xFFFE.
    - chan_last < chan_first or type 3: no effect.
  - setvec and chan kill hitting the same thread in the same cycle: chan kill wins.
- States:
  - IDLE: on frame_start go to APPLY with idx = 0. frame_start in any other state is ignored.
  - APPLY: one thread per cycle.
    - req_pc == 0xFFFE: pc = 0xFFFF.
    - Otherwise, req_pc != 0xFFFF: pc = req_pc.
    - req_pause_vld: paused = req_pause.
    - Then clear requests. A request captured for the same idx in the same cycle is kept for the next frame.
    - After idx = NUM_THREADS-1, go to SCAN with idx = 0.
  - SCAN: one thread per cycle.
    - If pc[idx] != 0xFFFF and !paused[idx], go to DISPATCH.
    - Otherwise idx++. After the last thread, go to FINISH.
  - DISPATCH: run_valid = 1 with run_id = idx and run_pc = pc[idx], held stable until run_ready. Then go to WAIT; run_valid drops the next cycle.
  - WAIT: on done_valid:
    - pc[idx] = done_kill ? 0xFFFF : done_pc.
    - idx++, return to SCAN, or go to FINISH after the last thread.
    - done_valid outside WAIT is ignored.
  - FINISH: frame_done = 1 for one cycle, then IDLE.
- Timing: with no runnable thread, frame_done is high in cycle 2*NUM_THREADS+1 after the frame_start sample edge.
- Requests raised while a thread runs take effect next frame, never the current one.

Optional Feature:
- Macro: ANOTHERWORLD_SCHED_STATS_EN.
- Defined: adds output dispatch_count[7:0]. It counts run_valid && run_ready handshakes in the frame, saturates at 255, is updated at FINISH, holds until the next FINISH, and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, frame_start, CPU yields done_pc = 0x0042 -> run_id = 0, run_pc = 0x0000. The next frame dispatches thread 0 with run_pc = 0x0042. frame_done is asserted once per frame.
- setvec id = 5 pc = 0x1234 during WAIT of thread 0 -> thread 5 is not run this frame. The next frame runs thread 0 then thread 5 with run_pc = 0x1234.
- chan first = 3 last = 6 type = 1 on active threads 3..6 -> none dispatched the next frame. A later type = 0 restores dispatch of 3..6 in order.
- chan type = 2 and setvec to the same thread in the same cycle -> thread killed. Also: done_kill = 1 -> thread never dispatched again until a new setvec.
- All threads inactive after a kill, then frame_start -> no run_valid, frame_done exactly 129 cycles later (NUM_THREADS = 64).
- Hold run_ready low for 10 cycles -> run_valid, run_id and run_pc stay stable. Assert reset mid-WAIT -> all outputs 0 and pc[0] = 0 immediately.
